// File: rtl/uart8_transmitter_pkg.sv
// Shared definitions for the 8-bit UART transmit path.
//   txState_t          transmitter FSM states
//   DATA_BITS_N        data bits per frame (8N1 framing)
//   DEFAULT_CLOCK_RATE system clock in Hz (Alhambra board)
//   DEFAULT_BAUD_RATE  line rate in bits/s
//   bitCycles()        clk cycles per bit, integer division
package uart8_transmitter_pkg;

  localparam int unsigned DATA_BITS_N        = 8;
  localparam int unsigned DEFAULT_CLOCK_RATE = 12000000;
  localparam int unsigned DEFAULT_BAUD_RATE  = 9600;

  typedef enum logic [2:0] {
    Idle,
    StartBit,
    DataBits,
    StopBit,
    Done
  } txState_t;

  // A result of 0 would make the divider meaningless, so clamp to at least one cycle per bit.
  function automatic int unsigned bitCycles(input int unsigned clockRate,
                                            input int unsigned baudRate);
    int unsigned cycles;
    cycles = clockRate / baudRate;
    if (cycles == 0) begin
      cycles = 1;
    end
    return cycles;
  endfunction

endpackage

// File: rtl/uart8_transmitter_if.sv
// Handshake and line signals of the UART transmitter.
//   txEn     enable; frames start only while high
//   txStart  request to send `in`
//   in       byte to transmit
//   out      serial tx line, idle high
//   txBusy   frame in flight
//   txDone   one-clk pulse after the stop bit
// master: the client issuing bytes. slave: the transmitter.
interface uart8_transmitter_if;

  logic       txEn;
  logic       txStart;
  logic [7:0] in;
  logic       out;
  logic       txBusy;
  logic       txDone;

  modport master (
    output txEn,
    output txStart,
    output in,
    input  out,
    input  txBusy,
    input  txDone
  );

  modport slave (
    input  txEn,
    input  txStart,
    input  in,
    output out,
    output txBusy,
    output txDone
  );

endinterface

// File: rtl/uart8_transmitter_baud_tick_gen.sv
// Bit-period divider. Emits a one-clk strobe on the last cycle of every CLOCK_RATE/BAUD_RATE
// cycle period. The divisor is a parameter, so the same block can serve a receiver's
// oversampling generator.
//   clk      system clock
//   reset    asynchronous, active-high reset
//   restart  clear the count so the next period starts on the following cycle
//   tick     high on the final cycle of each period
module baud_tick_gen
  import uart8_transmitter_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = DEFAULT_CLOCK_RATE,
  parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned BIT_CYCLES = bitCycles(CLOCK_RATE, BAUD_RATE);
  localparam int unsigned CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countD;

  assign tick = (count == LAST);

  always_comb begin
    countD = count + CNT_W'(1);
    if (restart || tick) begin
      countD = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= countD;
    end
  end

endmodule

// File: rtl/uart8_transmitter.sv
// Serial transmit half of the 8-bit UART. Sends one 8N1 frame per accepted request:
// start bit 0, eight data bits LSB first, stop bit 1. Each bit lasts CLOCK_RATE/BAUD_RATE clks.
//   clk    system clock
//   reset  asynchronous, active-high reset; aborts any frame and returns the line high
//   bus    slave side of uart8_transmitter_if (txEn, txStart, in / out, txBusy, txDone)
// All outputs come from registers, so the line is glitch-free.
module uart8_transmitter
  import uart8_transmitter_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = DEFAULT_CLOCK_RATE,
  parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE
) (
  input  logic                  clk,
  input  logic                  reset,
  uart8_transmitter_if.slave    bus
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS_N - 1);

  txState_t   state;
  txState_t   stateD;
  logic [7:0] shift;
  logic [7:0] shiftD;
  logic [2:0] bitIdx;
  logic [2:0] bitIdxD;
  logic       outReg;
  logic       outD;
  logic       busyReg;
  logic       busyD;
  logic       doneReg;
  logic       doneD;
  logic       restart;
  logic       bitTick;

  baud_tick_gen #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE)
  ) uBaud (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (bitTick)
  );

  // Next-state logic. The divider is only restarted on accept, so each frame's bit timing is
  // anchored to its own start bit.
  always_comb begin
    stateD  = state;
    shiftD  = shift;
    bitIdxD = bitIdx;
    restart = 1'b0;

    unique case (state)
      Idle: begin
        if (bus.txEn && bus.txStart) begin
          shiftD  = bus.in;
          restart = 1'b1;
          stateD  = StartBit;
        end
      end
      StartBit: begin
        if (bitTick) begin
          bitIdxD = '0;
          stateD  = DataBits;
        end
      end
      DataBits: begin
        if (bitTick) begin
          shiftD  = {1'b0, shift[7:1]};
          bitIdxD = bitIdx + 3'd1;
          if (bitIdx == LAST_BIT) begin
            stateD = StopBit;
          end
        end
      end
      StopBit: begin
        if (bitTick) begin
          stateD = Done;
        end
      end
      Done: begin
        // Requests seen here are dropped; the earliest accept is in the following Idle cycle.
        stateD = Idle;
      end
      default: begin
        stateD = Idle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state,
  // giving one clk from an accepted txStart to the start bit on the line.
  always_comb begin
    outD  = 1'b1;
    busyD = 1'b0;
    doneD = 1'b0;
    unique case (stateD)
      StartBit: begin
        outD  = 1'b0;
        busyD = 1'b1;
      end
      DataBits: begin
        outD  = shiftD[0];
        busyD = 1'b1;
      end
      StopBit: begin
        busyD = 1'b1;
      end
      Done: begin
        doneD = 1'b1;
      end
      default: begin
        outD = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= Idle;
      shift   <= '0;
      bitIdx  <= '0;
      outReg  <= 1'b1;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      state   <= stateD;
      shift   <= shiftD;
      bitIdx  <= bitIdxD;
      outReg  <= outD;
      busyReg <= busyD;
      doneReg <= doneD;
    end
  end

  assign bus.out    = outReg;
  assign bus.txBusy = busyReg;
  assign bus.txDone = doneReg;

endmodule

// File: tb/tb_uart8_transmitter.sv
// Directed bench for uart8_transmitter. Runs at a reduced clock so every scenario fits a short
// simulation: 120000 / 9600 = 12.5, truncated to 12 clks per bit.
module tb_uart8_transmitter;

  localparam int unsigned CLOCK_RATE = 120000;
  localparam int unsigned BAUD_RATE  = 9600;
  localparam int          N          = 12;

  logic clk = 1'b0;
  logic reset;

  uart8_transmitter_if bus();

  uart8_transmitter #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Advance one clk; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level at cycle c of a frame (cycle 0 = first start-bit cycle).
  function automatic logic expBit(input logic [7:0] d, input int c);
    if (c < N) return 1'b0;
    else if (c < 9 * N) return d[(c - N) / N];
    else return 1'b1;
  endfunction

  // Request a frame from the Idle state; returns at cycle 0 of the frame.
  task automatic startFrame(input logic [7:0] d);
    bus.in      = d;
    bus.txStart = 1'b1;
    tick();
    bus.txStart = 1'b0;
  endtask

  // Follow a frame from cycle 0, counting line/busy deviations from the model. Returns the cycle
  // txDone was seen (-1 if never, within a bound) and the ten bit-centre samples.
  task automatic watchFrame(input logic [7:0] d, output int errs, output int doneAt,
                            output logic [9:0] centres);
    errs    = 0;
    doneAt  = -1;
    centres = '0;
    for (int c = 0; c < 10 * N + 4; c++) begin
      if (bus.txDone === 1'b1) begin
        doneAt = c;
        if (bus.txBusy !== 1'b0 || bus.out !== 1'b1) errs++;
        break;
      end
      if (c >= 10 * N) begin
        errs++;
      end else begin
        if (bus.out !== expBit(d, c) || bus.txBusy !== 1'b1) errs++;
        if (c % N == N / 2) centres[c / N] = bus.out;
      end
      tick();
    end
  endtask

  // Count cycles within n where the line is not idle.
  task automatic watchIdle(input int n, output int bad);
    bad = 0;
    for (int c = 0; c < n; c++) begin
      if (bus.out !== 1'b1 || bus.txBusy !== 1'b0 || bus.txDone !== 1'b0) bad++;
      tick();
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.out !== 1'b1 || bus.txBusy !== 1'b0 || bus.txDone !== 1'b0)
      $display("FAIL reset_values out=%b busy=%b done=%b required 1/0/0",
               bus.out, bus.txBusy, bus.txDone);
    else passes++;
    bus.txEn    = 1'b1;
    bus.txStart = 1'b0;
    reset       = 1'b0;
    watchIdle(5000, bad);
    checks++;
    if (bad !== 0) $display("FAIL reset_idle bad_cycles=%0d required 0", bad);
    else passes++;
  endtask

  task automatic test_single_frame();
    int errs, doneAt;
    logic [9:0] centres;
    startFrame(8'b00110101);
    checks++;
    if (bus.out !== 1'b0 || bus.txBusy !== 1'b1)
      $display("FAIL single_latency out=%b busy=%b required 0/1", bus.out, bus.txBusy);
    else passes++;
    watchFrame(8'b00110101, errs, doneAt, centres);
    checks++;
    // Centres, start first: 0,1,0,1,0,1,1,0,0,1 -> packed with index 0 at the right.
    if (centres !== 10'b1001101010)
      $display("FAIL single_centres got=%b required %b", centres, 10'b1001101010);
    else passes++;
    checks++;
    if (errs !== 0) $display("FAIL single_hold bad_cycles=%0d required 0", errs);
    else passes++;
    checks++;
    if (doneAt !== 10 * N) $display("FAIL single_done_cycle got=%0d required %0d", doneAt, 10 * N);
    else passes++;
    tick();
    checks++;
    if (bus.txDone !== 1'b0) $display("FAIL single_done_pulse txDone=%b required 0", bus.txDone);
    else passes++;
  endtask

  // Deserialise the line at bit centres, as a receiver would.
  task automatic test_loopback();
    int errs, doneAt;
    logic [9:0] centres;
    logic [7:0] bytes[2];
    bytes[0] = 8'hA5;
    bytes[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      startFrame(bytes[i]);
      watchFrame(bytes[i], errs, doneAt, centres);
      checks++;
      if (centres[8:1] !== bytes[i] || doneAt !== 10 * N)
        $display("FAIL loopback_data got=%h done=%0d required %h done=%0d",
                 centres[8:1], doneAt, bytes[i], 10 * N);
      else passes++;
      checks++;
      if (centres[0] !== 1'b0 || centres[9] !== 1'b1)
        $display("FAIL loopback_framing start=%b stop=%b required 0/1", centres[0], centres[9]);
      else passes++;
      tick();
    end
  endtask

  task automatic test_busy_reject();
    int errs, doneAt, bad;
    logic [9:0] centres;
    startFrame(8'h0F);
    fork
      begin
        repeat (4 * N + N / 2) tick();
        bus.in      = 8'hFF;
        bus.txStart = 1'b1;
        tick();
        bus.txStart = 1'b0;
      end
    join_none
    watchFrame(8'h0F, errs, doneAt, centres);
    checks++;
    if (errs !== 0 || centres[8:1] !== 8'h0F)
      $display("FAIL busy_frame errs=%0d data=%h required 0 and 0f", errs, centres[8:1]);
    else passes++;
    tick();
    watchIdle(3 * N, bad);
    checks++;
    if (bad !== 0) $display("FAIL busy_no_second bad_cycles=%0d required 0", bad);
    else passes++;
  endtask

  task automatic test_enable();
    int errs, doneAt, bad;
    logic [9:0] centres;
    bus.txEn = 1'b0;
    startFrame(8'h81);
    watchIdle(2 * N, bad);
    checks++;
    if (bad !== 0) $display("FAIL enable_off bad_cycles=%0d required 0", bad);
    else passes++;

    bus.txEn = 1'b1;
    startFrame(8'hC3);
    fork
      begin
        repeat (3 * N) tick();
        bus.txEn = 1'b0;
      end
    join_none
    watchFrame(8'hC3, errs, doneAt, centres);
    checks++;
    if (errs !== 0 || doneAt !== 10 * N)
      $display("FAIL enable_drop errs=%0d done=%0d required 0 and %0d", errs, doneAt, 10 * N);
    else passes++;
    tick();

    startFrame(8'h12);
    watchIdle(2 * N, bad);
    checks++;
    if (bad !== 0) $display("FAIL enable_still_off bad_cycles=%0d required 0", bad);
    else passes++;

    bus.txEn = 1'b1;
    startFrame(8'h12);
    watchFrame(8'h12, errs, doneAt, centres);
    checks++;
    if (errs !== 0 || doneAt !== 10 * N)
      $display("FAIL enable_resume errs=%0d done=%0d required 0 and %0d", errs, doneAt, 10 * N);
    else passes++;
    tick();
  endtask

  task automatic test_reset_mid();
    int errs, doneAt;
    logic [9:0] centres;
    startFrame(8'h96);
    repeat (6 * N + N / 2) tick();
    // 0x96 bit 5 is 0, so the line is low here until reset forces it high.
    checks++;
    if (bus.out !== 1'b0) $display("FAIL reset_mid_bit5 out=%b required 0", bus.out);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out !== 1'b1 || bus.txBusy !== 1'b0)
      $display("FAIL reset_mid_async out=%b busy=%b required 1/0", bus.out, bus.txBusy);
    else passes++;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    startFrame(8'h3C);
    watchFrame(8'h3C, errs, doneAt, centres);
    checks++;
    if (errs !== 0 || doneAt !== 10 * N || centres[8:1] !== 8'h3C)
      $display("FAIL reset_mid_after errs=%0d done=%0d data=%h required 0, %0d, 3c",
               errs, doneAt, centres[8:1], 10 * N);
    else passes++;
    tick();
  endtask

  // With txStart held, the gap after txDone is the single Idle cycle where the next accept lands.
  task automatic test_back_to_back();
    int errs, doneAt, bad;
    logic [9:0] centres;
    bus.in      = 8'h55;
    bus.txStart = 1'b1;
    tick();
    bus.in = 8'hAA;
    watchFrame(8'h55, errs, doneAt, centres);
    checks++;
    if (errs !== 0 || doneAt !== 10 * N)
      $display("FAIL b2b_first errs=%0d done=%0d required 0 and %0d", errs, doneAt, 10 * N);
    else passes++;
    tick();
    checks++;
    if (bus.out !== 1'b1 || bus.txBusy !== 1'b0 || bus.txDone !== 1'b0)
      $display("FAIL b2b_gap out=%b busy=%b done=%b required 1/0/0",
               bus.out, bus.txBusy, bus.txDone);
    else passes++;
    tick();
    checks++;
    if (bus.out !== 1'b0 || bus.txBusy !== 1'b1)
      $display("FAIL b2b_second_start out=%b busy=%b required 0/1", bus.out, bus.txBusy);
    else passes++;
    bus.txStart = 1'b0;
    watchFrame(8'hAA, errs, doneAt, centres);
    checks++;
    if (errs !== 0 || doneAt !== 10 * N || centres[8:1] !== 8'hAA)
      $display("FAIL b2b_second errs=%0d done=%0d data=%h required 0, %0d, aa",
               errs, doneAt, centres[8:1], 10 * N);
    else passes++;
    tick();
    watchIdle(2 * N, bad);
    checks++;
    if (bad !== 0) $display("FAIL b2b_no_third bad_cycles=%0d required 0", bad);
    else passes++;
  endtask

  initial begin
    bus.txEn    = 1'b1;
    bus.txStart = 1'b0;
    bus.in      = 8'h00;
    test_reset();
    test_single_frame();
    test_loopback();
    test_busy_reject();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
